// File: rtl/immobilizer_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : immobilizer_sequencer
// Brief    : Gates fuel pump and starter behind a held hidden-switch + brake
//            combo, counting failed windows and enforcing a timed lockout.
//            Optional alarm output enabled by defining ANTI_THEFT_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module immobilizer_sequencer #(
    parameter int HOLD_CYCLES    = 8,
    parameter int AUTH_TIMEOUT   = 64,
    parameter int PRIME_CYCLES   = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ignition_on,
    input  logic                           hidden_switch,
    input  logic                           brake_pressed,
    output logic                           fuel_pump_on,
    output logic                           starter_enable,
    output logic                           authorized,
    output logic                           locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count,
    output logic [2:0]                     state
`ifdef ANTI_THEFT_ALARM_EN
    ,
    output logic                           alarm
`endif
);

    localparam int c_hold_w  = $clog2(HOLD_CYCLES + 1);
    localparam int c_auth_w  = $clog2(AUTH_TIMEOUT + 1);
    localparam int c_prime_w = $clog2(PRIME_CYCLES + 1);
    localparam int c_fail_w  = $clog2(MAX_FAILS + 1);
    // At least 4 bits so bit 3 of the lockout timer can pace the alarm.
    localparam int c_lock_w  = ($clog2(LOCKOUT_CYCLES + 1) < 4) ? 4 : $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [c_hold_w-1:0]  c_hold_one  = c_hold_w'(1);
    localparam logic [c_hold_w-1:0]  c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_auth_w-1:0]  c_auth_last = c_auth_w'(AUTH_TIMEOUT - 1);
    localparam logic [c_prime_w-1:0] c_prime_last = c_prime_w'(PRIME_CYCLES - 1);
    localparam logic [c_fail_w-1:0]  c_fail_last = c_fail_w'(MAX_FAILS - 1);
    localparam logic [c_fail_w-1:0]  c_fail_max  = c_fail_w'(MAX_FAILS);
    localparam logic [c_lock_w-1:0]  c_lock_last = c_lock_w'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        c_st_idle    = 3'd0,
        c_st_wait    = 3'd1,
        c_st_hold    = 3'd2,
        c_st_prime   = 3'd3,
        c_st_run     = 3'd4,
        c_st_lockout = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_hold_w-1:0]  r_hold_cnt;
    logic [c_auth_w-1:0]  r_auth_cnt;
    logic [c_prime_w-1:0] r_prime_cnt;
    logic [c_fail_w-1:0]  r_fail_cnt;
    logic [c_lock_w-1:0]  r_lockout_cnt;

    logic w_combo;
    logic w_hold_done;
    logic w_auth_expired;
    logic w_fail_last;

    assign w_combo        = hidden_switch & brake_pressed;
    assign w_hold_done    = (r_hold_cnt == c_hold_last);
    assign w_auth_expired = (r_auth_cnt == c_auth_last);
    assign w_fail_last    = (r_fail_cnt == c_fail_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= c_st_idle;
            r_hold_cnt    <= '0;
            r_auth_cnt    <= '0;
            r_prime_cnt   <= '0;
            r_fail_cnt    <= '0;
            r_lockout_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (ignition_on) begin
                        r_state    <= c_st_wait;
                        r_auth_cnt <= '0;
                        r_hold_cnt <= '0;
                    end
                end
                c_st_wait, c_st_hold: begin
                    if (!ignition_on) begin
                        r_state    <= c_st_idle;
                        r_hold_cnt <= '0;
                    end else if (r_state == c_st_hold && w_combo && w_hold_done) begin
                        // completion outranks a timeout landing on the same edge
                        r_state     <= c_st_prime;
                        r_hold_cnt  <= '0;
                        r_prime_cnt <= '0;
                        r_fail_cnt  <= '0;
                    end else if (w_auth_expired) begin
                        r_hold_cnt <= '0;
                        r_auth_cnt <= '0;
                        if (w_fail_last) begin
                            r_state       <= c_st_lockout;
                            r_fail_cnt    <= c_fail_max;
                            r_lockout_cnt <= '0;
                        end else begin
                            r_state    <= c_st_wait;
                            r_fail_cnt <= r_fail_cnt + 1'b1;
                        end
                    end else begin
                        r_auth_cnt <= r_auth_cnt + 1'b1;
                        if (!w_combo) begin
                            r_state    <= c_st_wait;
                            r_hold_cnt <= '0;
                        end else if (r_state == c_st_wait) begin
                            r_state    <= c_st_hold;
                            r_hold_cnt <= c_hold_one;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                c_st_prime: begin
                    if (!ignition_on) begin
                        r_state <= c_st_idle;
                    end else if (r_prime_cnt == c_prime_last) begin
                        r_state <= c_st_run;
                    end else begin
                        r_prime_cnt <= r_prime_cnt + 1'b1;
                    end
                end
                c_st_run: begin
                    if (!ignition_on) begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_lockout: begin
                    if (r_lockout_cnt == c_lock_last) begin
                        r_state    <= c_st_idle;
                        r_fail_cnt <= '0;
                    end else begin
                        r_lockout_cnt <= r_lockout_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign fuel_pump_on   = (r_state == c_st_prime) || (r_state == c_st_run);
    assign starter_enable = (r_state == c_st_run);
    assign authorized     = (r_state == c_st_run);
    assign locked_out     = (r_state == c_st_lockout);
    assign fail_count     = r_fail_cnt;
    assign state          = r_state;

`ifdef ANTI_THEFT_ALARM_EN
    assign alarm = (r_state == c_st_lockout) && !r_lockout_cnt[3];
`endif

endmodule

`default_nettype wire
